cdf_read_arbiter: RTL and testbench

Shares the single read port of the CDF lookup memory between two requesters: port 0 is the output-pipeline pixel fetch (the pixel value addresses the CDF entry), and port 1 is the CDF build/readback path. The block arbitrates with a bounded-burst sticky policy, drives the memory address and enable, and returns the selected byte lane of the 128-bit read word to the requester that issued the read. It sits between the requesters and the CDF RAM in the output pipeline.

---
 rtl/cdf_read_arbiter_pkg.sv | 21 ++
 rtl/cdf_read_arbiter_if.sv | 29 ++
 rtl/cdf_lane_select.sv | 12 +
 rtl/cdf_read_arbiter.sv | 122 ++++++++++++
 tb/tb_cdf_read_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/cdf_read_arbiter_pkg.sv
// rtl/cdf_read_arbiter_pkg.sv - shared types and constants for the CDF read arbiter
package cdf_read_arbiter_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 128;
    localparam int BYTE_W     = 8;
    localparam int LANE_W     = 4;
    localparam int WORD_SHIFT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    // Byte address to 128-bit word address; the low nibble becomes the lane.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] addr);
        return addr >> WORD_SHIFT;
    endfunction

endpackage

// File: rtl/cdf_read_arbiter_if.sv
// rtl/cdf_read_arbiter_if.sv - requester and CDF memory signals of the read arbiter
interface cdf_read_arbiter_if;
    import cdf_read_arbiter_pkg::*;

    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [BYTE_W-1:0] rdata0;
    logic [BYTE_W-1:0] rdata1;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req0, req1, addr0, addr1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_addr
    );

    modport slave (
        input  req0, req1, addr0, addr1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_addr
    );

endinterface

// File: rtl/cdf_lane_select.sv
// rtl/cdf_lane_select.sv - picks one byte lane out of a 128-bit CDF word
module cdf_lane_select
    import cdf_read_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] data_word,
    input  logic [LANE_W-1:0] lane,
    output logic [BYTE_W-1:0] lane_byte
);

    assign lane_byte = data_word[lane*BYTE_W +: BYTE_W];

endmodule

// File: rtl/cdf_read_arbiter.sv
// rtl/cdf_read_arbiter.sv - bounded-burst sticky arbiter for the CDF RAM read port
module cdf_read_arbiter
    import cdf_read_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 5
) (
    input  logic                clock,
    input  logic                reset,
    cdf_read_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    owner_e            state;
    owner_e            state_nxt;
    logic [CNT_W-1:0]  burst_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              grant0;
    logic              grant1;
    logic [ADDR_W-1:0] granted_addr;

    logic              ret_valid;
    logic              ret_port;
    logic [LANE_W-1:0] ret_lane;
    logic [BYTE_W-1:0] lane_byte;

    assign cnt_inc = (burst_cnt >= MAX_CNT) ? MAX_CNT : burst_cnt + CNT_ONE;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = burst_cnt;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0) begin
                    grant0    = 1'b1;
                    state_nxt = OWN0;
                    cnt_nxt   = CNT_ONE;
                end else if (bus.req1) begin
                    grant1    = 1'b1;
                    state_nxt = OWN1;
                    cnt_nxt   = CNT_ONE;
                end
            end
            OWN0: begin
                if (bus.req0 && (!bus.req1 || burst_cnt < MAX_CNT)) begin
                    grant0  = 1'b1;
                    cnt_nxt = cnt_inc;
                end else if (bus.req1) begin
                    grant1    = 1'b1;
                    state_nxt = OWN1;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            OWN1: begin
                if (bus.req1 && (!bus.req0 || burst_cnt < MAX_CNT)) begin
                    grant1  = 1'b1;
                    cnt_nxt = cnt_inc;
                end else if (bus.req0) begin
                    grant0    = 1'b1;
                    state_nxt = OWN0;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        // No port may see a grant while reset is held; that read would be lost anyway.
        if (reset) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
            ret_valid <= 1'b0;
            ret_port  <= 1'b0;
            ret_lane  <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= cnt_nxt;
            ret_valid <= grant0 | grant1;
            ret_port  <= grant1;
            ret_lane  <= granted_addr[LANE_W-1:0];
        end
    end

    assign granted_addr = grant1 ? bus.addr1 : bus.addr0;

    assign bus.gnt0     = grant0;
    assign bus.gnt1     = grant1;
    assign bus.mem_en   = grant0 | grant1;
    assign bus.mem_addr = (grant0 | grant1) ? word_addr(granted_addr) : '0;

    cdf_lane_select u_lane_select (
        .data_word (bus.mem_rdata),
        .lane      (ret_lane),
        .lane_byte (lane_byte)
    );

    // Returned data is masked during reset so an in-flight read never surfaces.
    assign bus.rvalid0 = ret_valid & ~ret_port & ~reset;
    assign bus.rvalid1 = ret_valid &  ret_port & ~reset;
    assign bus.rdata0  = bus.rvalid0 ? lane_byte : '0;
    assign bus.rdata1  = bus.rvalid1 ? lane_byte : '0;

endmodule

// File: tb/tb_cdf_read_arbiter.sv
// tb/tb_cdf_read_arbiter.sv - scoreboard bench for cdf_read_arbiter with MAX_BURST=4
module tb_cdf_read_arbiter;
    import cdf_read_arbiter_pkg::*;

    typedef struct {
        int          cyc;
        int          port;
        logic [15:0] maddr;
    } gnt_t;

    typedef struct {
        int          cyc;
        int          port;
        logic [7:0]  data;
    } ret_t;

    logic clock;
    logic reset;

    cdf_read_arbiter_if bus();

    cdf_read_arbiter #(.MAX_BURST(4), .CNT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int   checks;
    int   errors;
    int   cyc;
    bit   running;
    gnt_t gnt_q[$];
    ret_t ret_q[$];
    bit   pend_valid;
    int   pend_port;
    logic [7:0] pend_data;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: byte k of word w is {w[3:0], k} ^ 8'h86, one cycle after the address.
    always @(posedge clock) begin
        for (int k = 0; k < 16; k++)
            bus.mem_rdata[8*k +: 8] <= {bus.mem_addr[3:0], 4'(k)} ^ 8'h86;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit r0, input bit r1,
                        input logic [15:0] a0, input logic [15:0] a1, input int expg);
        logic [15:0] ga;
        reset     = rst;
        bus.req0  = r0;
        bus.req1  = r1;
        bus.addr0 = a0;
        bus.addr1 = a1;
        if (pend_valid && !rst)
            ret_q.push_back('{cyc, pend_port, pend_data});
        pend_valid = 1'b0;
        if (expg != 0) begin
            ga = (expg == 1) ? a0 : a1;
            gnt_q.push_back('{cyc, expg, {4'h0, ga[15:4]}});
            pend_valid = 1'b1;
            pend_port  = expg;
            pend_data  = ga[7:0] ^ 8'h86;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    always @(negedge clock) begin : monitor
        int          ep;
        logic [15:0] ea;
        int          rp;
        logic [7:0]  rd;
        gnt_t        g;
        ret_t        r;
        if (running) begin
            ep = 0;
            ea = '0;
            if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
                g  = gnt_q.pop_front();
                ep = g.port;
                ea = g.maddr;
            end
            check("gnt", 32'({bus.gnt1, bus.gnt0}), 32'((ep == 1) ? 2'b01 : (ep == 2) ? 2'b10 : 2'b00));
            check("mem_en", 32'(bus.mem_en), 32'(ep != 0));
            check("mem_addr", 32'(bus.mem_addr), 32'(ea));
            rp = 0;
            rd = '0;
            if (ret_q.size() > 0 && ret_q[0].cyc == cyc) begin
                r  = ret_q.pop_front();
                rp = r.port;
                rd = r.data;
            end
            check("rvalid", 32'({bus.rvalid1, bus.rvalid0}), 32'((rp == 1) ? 2'b01 : (rp == 2) ? 2'b10 : 2'b00));
            check("rdata0", 32'(bus.rdata0), 32'((rp == 1) ? rd : 8'h00));
            check("rdata1", 32'(bus.rdata1), 32'((rp == 2) ? rd : 8'h00));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        running    = 1'b0;
        pend_valid = 1'b0;
        pend_port  = 0;
        pend_data  = '0;
        reset      = 1'b1;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.addr0  = '0;
        bus.addr1  = '0;
        @(posedge clock);
        #1;
        running = 1'b1;

        step(1, 0, 0, 16'h0000, 16'h0000, 0);
        step(1, 0, 0, 16'h0000, 16'h0000, 0);

        // Single read: word 2, lane 3, expected byte A5 one cycle later.
        step(0, 1, 0, 16'h0023, 16'h0000, 1);
        step(0, 0, 0, 16'h0000, 16'h0000, 0);

        // Contention from IDLE: four grants to port 0, four to port 1, back to 0.
        step(0, 1, 1, 16'h0100, 16'h0201, 1);
        step(0, 1, 1, 16'h0112, 16'h0201, 1);
        step(0, 1, 1, 16'h0124, 16'h0201, 1);
        step(0, 1, 1, 16'h0137, 16'h0201, 1);
        step(0, 1, 1, 16'h0148, 16'h0201, 2);
        step(0, 1, 1, 16'h0148, 16'h0245, 2);
        step(0, 1, 1, 16'h0148, 16'h02AB, 2);
        step(0, 1, 1, 16'h0148, 16'h02FF, 2);
        step(0, 1, 1, 16'h0148, 16'h0333, 1);
        // Owner drops while the other requests: immediate switch.
        step(0, 0, 1, 16'h0000, 16'h0333, 2);
        check("burst_after_switch", 32'(dut.burst_cnt), 32'd1);
        step(0, 0, 0, 16'h0000, 16'h0000, 0);

        // Lone owner for 40 cycles: counter saturates at MAX_BURST.
        for (int i = 0; i < 40; i++)
            step(0, 1, 0, 16'h1000 + 16'(i * 17), 16'h0000, 1);
        check("burst_saturated", 32'(dut.burst_cnt), 32'd4);
        check("state_own0", 32'(dut.state), 32'(OWN0));
        step(0, 1, 1, 16'h2000, 16'h3456, 2);
        step(0, 0, 1, 16'h0000, 16'h3789, 2);

        // Reset right after a port 1 grant discards its return.
        step(1, 1, 1, 16'h4000, 16'h4111, 0);
        check("state_after_reset", 32'(dut.state), 32'(IDLE));
        check("burst_after_reset", 32'(dut.burst_cnt), 32'd0);
        step(0, 1, 1, 16'h4000, 16'h4111, 1);
        step(0, 0, 0, 16'h0000, 16'h0000, 0);
        step(0, 0, 0, 16'h0000, 16'h0000, 0);

        @(negedge clock);
        running = 1'b0;
        check("gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
        check("ret_queue_drained", 32'(ret_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
